// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and its consumers.
package fetch_pkg;

  localparam int OPCODE_W = 4;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    HOLD,
    DRAIN,
    HALTED
  } fetch_state_e;

  localparam logic [OPCODE_W-1:0] OP_ADD    = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_AND    = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OR     = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_HALT   = 4'hF;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Pair of saturating event counters (accepted fetches, downstream stalls).
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [1:0] inc;
  assign inc = {stall_inc, fetch_inc};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg <= '0;
      end else if (inc[gi] && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign fetch_cnt = g_cnt[0].cnt_reg;
  assign stall_cnt = g_cnt[1].cnt_reg;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage with redirect and HALT support.
// Optional perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_valid,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [ADDR_W-1:0]   out_pc,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    fetch_cnt,
  output logic [CNT_W-1:0]    stall_cnt
`endif
);

  fetch_state_e       state_reg, state_next;
  logic [ADDR_W-1:0]  pc_reg, pc_next;
  logic [INSTR_W-1:0] instr_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;
  logic               capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // A redirect always wins over data or acceptance in the same cycle.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    capture    = 1'b0;
    unique case (state_reg)
      FETCH: begin
        if (redirect_valid) begin
          state_next = DRAIN;
          pc_next    = redirect_pc;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_valid && redirect_valid) begin
          state_next = FETCH;
          pc_next    = redirect_pc;
        end else if (imem_valid) begin
          state_next = HOLD;
          pc_next    = pc_reg + ADDR_W'(1);
          capture    = 1'b1;
        end else if (redirect_valid) begin
          state_next = DRAIN;
          pc_next    = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_next = FETCH;
          pc_next    = redirect_pc;
        end else if (out_ready) begin
          state_next = (out_opcode == OP_HALT) ? HALTED : FETCH;
        end
      end
      DRAIN: begin
        // Once the stale word lands nothing is outstanding, even if redirected again.
        if (redirect_valid) pc_next = redirect_pc;
        if (imem_valid) state_next = FETCH;
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_comb begin
    imem_req  = rst_n && (state_reg == FETCH);
    out_valid = (state_reg == HOLD);
    halted    = (state_reg == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
      if (capture) begin
        instr_reg    <= imem_rdata;
        instr_pc_reg <= pc_reg;
      end
    end
  end

  assign imem_addr  = pc_reg;
  assign out_instr  = instr_reg;
  assign out_opcode = instr_reg[INSTR_W-1 -: OPCODE_W];
  assign out_pc     = instr_pc_reg;

`ifdef FETCH_PERF_CNT_EN
  logic fetch_inc, stall_inc;
  assign fetch_inc = (state_reg == HOLD) && out_ready && !redirect_valid;
  assign stall_inc = out_valid && !out_ready;

  fetch_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_inc (fetch_inc),
    .stall_inc (stall_inc),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt)
  );
`else
  // Counter ports and logic are absent in this build.
`endif

endmodule
